// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C register target.
package i2c_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StAddr,
        StIgnore,
        StAckPtr,
        StPtr,
        StAckW,
        StWdata,
        StAckRaddr,
        StRdata,
        StMack,
        StRwait
    } i2c_tgt_state_t;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;

    localparam int unsigned I2C_BITS = 8;

endpackage

// File: rtl/i2c_reg_target_if.sv
// Register-bank side of the I2C target: write strobes out, read requests out, read data in.
interface i2c_reg_target_if #(
    parameter int unsigned PTR_W = 8
);
    logic             wr_valid;
    logic [PTR_W-1:0] wr_addr;
    logic [7:0]       wr_data;
    logic             rd_strobe;
    logic [PTR_W-1:0] rd_addr;
    logic [7:0]       rd_data;

    modport master (
        output wr_valid, wr_addr, wr_data, rd_strobe, rd_addr,
        input  rd_data
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data, rd_strobe, rd_addr,
        output rd_data
    );
endinterface

// File: rtl/i2c_line_cond.sv
// Per-line conditioning: 2-FF synchroniser, optional glitch filter, edge detection.
// The filter is built only when I2C_RTARGET_GLITCH_FILTER_EN is defined.
module i2c_line_cond #(
    parameter int unsigned FILTER_LEN = 3
) (
    input  logic clock,
    input  logic reset_n,
    input  logic line,
    output logic level,
    output logic rise,
    output logic fall
);
`ifdef I2C_RTARGET_GLITCH_FILTER_EN
    localparam bit FilterEn = 1'b1;
`else
    localparam bit FilterEn = 1'b0;
`endif
    localparam int unsigned Depth = FilterEn ? FILTER_LEN : 0;

    logic sync1_q, sync2_q, prev_q;

    // Preset high so an idle bus reads as released after reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= line;
            sync2_q <= sync1_q;
        end
    end

    if (Depth > 0) begin : g_filter
        localparam int unsigned CntW = $clog2(Depth + 1);
        logic [CntW-1:0] cnt_q;
        logic            filt_q;

        // Level follows the input only after Depth consecutive differing samples.
        always_ff @(posedge clock) begin
            if (!reset_n) begin
                filt_q <= 1'b1;
                cnt_q  <= '0;
            end else if (sync2_q == filt_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CntW'(Depth - 1)) begin
                filt_q <= sync2_q;
                cnt_q  <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end

        assign level = filt_q;
    end else begin : g_no_filter
        assign level = sync2_q;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            prev_q <= 1'b1;
        end else begin
            prev_q <= level;
        end
    end

    assign rise = level & ~prev_q;
    assign fall = ~level & prev_q;

endmodule

// File: rtl/i2c_reg_target.sv
// I2C target with register pointer, auto-incrementing burst reads/writes and open-drain SDA.
// Optional glitch filtering on SCL/SDA via I2C_RTARGET_GLITCH_FILTER_EN.
module i2c_reg_target
    import i2c_pkg::*;
#(
    parameter logic [6:0]  I2C_ADDRESS = 7'h49,
    parameter int unsigned NUM_REGS    = 16,
    parameter int unsigned PTR_W       = 8,
    parameter int unsigned FILTER_LEN  = 3
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             scl_in,
    input  logic             sda_in,
    output logic             sda_oe,
    output logic             busy,
    output logic             ptr_err,
    i2c_reg_target_if.master bus
);

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;

    i2c_line_cond #(.FILTER_LEN(FILTER_LEN)) u_scl_cond (
        .clock   (clock),
        .reset_n (reset_n),
        .line    (scl_in),
        .level   (scl_lvl),
        .rise    (scl_rise),
        .fall    (scl_fall)
    );

    i2c_line_cond #(.FILTER_LEN(FILTER_LEN)) u_sda_cond (
        .clock   (clock),
        .reset_n (reset_n),
        .line    (sda_in),
        .level   (sda_lvl),
        .rise    (sda_rise),
        .fall    (sda_fall)
    );

    logic start_det, stop_det;
    assign start_det = scl_lvl & sda_fall;
    assign stop_det  = scl_lvl & sda_rise;

    i2c_tgt_state_t   state_q;
    logic [2:0]       bit_cnt_q;
    logic [7:0]       shreg_q;
    logic             byte_done_q;
    logic             fetch_q;
    logic             load_wait_q;
    logic             load_now_q;
    logic [PTR_W-1:0] ptr_q;
    logic             wr_valid_q, rd_strobe_q;
    logic [PTR_W-1:0] wr_addr_q, rd_addr_q;
    logic [7:0]       wr_data_q;

    logic       last_bit, rx_state;
    logic [7:0] rx_byte;
    assign last_bit = (bit_cnt_q == 3'(I2C_BITS - 1));
    assign rx_byte  = {shreg_q[6:0], sda_lvl};
    assign rx_state = (state_q == StAddr) || (state_q == StPtr) || (state_q == StWdata);

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(NUM_REGS - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            byte_done_q <= 1'b0;
            fetch_q     <= 1'b0;
            load_wait_q <= 1'b0;
            load_now_q  <= 1'b0;
            ptr_q       <= '0;
            sda_oe      <= 1'b0;
            busy        <= 1'b0;
            ptr_err     <= 1'b0;
            wr_valid_q  <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            rd_strobe_q <= 1'b0;
            rd_addr_q   <= '0;
        end else begin
            wr_valid_q  <= 1'b0;
            rd_strobe_q <= 1'b0;
            // Bus conditions win over any SCL edge seen in the same cycle.
            if (stop_det) begin
                state_q     <= StIdle;
                sda_oe      <= 1'b0;
                busy        <= 1'b0;
                byte_done_q <= 1'b0;
                fetch_q     <= 1'b0;
                load_wait_q <= 1'b0;
                load_now_q  <= 1'b0;
            end else if (start_det) begin
                state_q     <= StAddr;
                bit_cnt_q   <= '0;
                byte_done_q <= 1'b0;
                fetch_q     <= 1'b0;
                load_wait_q <= 1'b0;
                load_now_q  <= 1'b0;
                sda_oe      <= 1'b0;
                ptr_err     <= 1'b0;
            end else begin
                // Read data arrives the cycle after rd_strobe; it is captured one cycle later.
                load_wait_q <= 1'b0;
                load_now_q  <= load_wait_q;
                if (load_now_q) begin
                    shreg_q <= bus.rd_data;
                    sda_oe  <= ~bus.rd_data[7];
                end

                if (rx_state && scl_rise) begin
                    shreg_q     <= rx_byte;
                    bit_cnt_q   <= bit_cnt_q + 3'd1;
                    byte_done_q <= last_bit;
                end

                case (state_q)
                    StAddr: begin
                        if (scl_fall && byte_done_q) begin
                            byte_done_q <= 1'b0;
                            if (shreg_q[7:1] == I2C_ADDRESS) begin
                                sda_oe  <= ~I2C_ACK;
                                busy    <= 1'b1;
                                state_q <= shreg_q[0] ? StAckRaddr : StAckPtr;
                            end else begin
                                state_q <= StIgnore;
                            end
                        end
                    end
                    StAckPtr: begin
                        if (scl_fall) begin
                            sda_oe  <= 1'b0;
                            state_q <= StPtr;
                        end
                    end
                    StPtr: begin
                        if (scl_fall && byte_done_q) begin
                            byte_done_q <= 1'b0;
                            if (32'(shreg_q) < NUM_REGS) begin
                                ptr_q   <= PTR_W'(shreg_q);
                                sda_oe  <= ~I2C_ACK;
                                state_q <= StAckW;
                            end else begin
                                ptr_err <= 1'b1;
                                busy    <= 1'b0;
                                state_q <= StIgnore;
                            end
                        end
                    end
                    StAckW: begin
                        if (scl_fall) begin
                            sda_oe  <= 1'b0;
                            state_q <= StWdata;
                        end
                    end
                    StWdata: begin
                        if (scl_rise && last_bit) begin
                            wr_valid_q <= 1'b1;
                            wr_addr_q  <= ptr_q;
                            wr_data_q  <= rx_byte;
                            ptr_q      <= ptr_inc(ptr_q);
                        end else if (scl_fall && byte_done_q) begin
                            byte_done_q <= 1'b0;
                            sda_oe      <= ~I2C_ACK;
                            state_q     <= StAckW;
                        end
                    end
                    StAckRaddr: begin
                        if (scl_fall) begin
                            sda_oe      <= 1'b0;
                            rd_strobe_q <= 1'b1;
                            rd_addr_q   <= ptr_q;
                            load_wait_q <= 1'b1;
                            state_q     <= StRdata;
                        end
                    end
                    StRdata: begin
                        if (fetch_q) begin
                            if (scl_fall) begin
                                fetch_q     <= 1'b0;
                                rd_strobe_q <= 1'b1;
                                rd_addr_q   <= ptr_q;
                                load_wait_q <= 1'b1;
                            end
                        end else if (!load_wait_q && !load_now_q) begin
                            if (scl_rise) begin
                                bit_cnt_q   <= bit_cnt_q + 3'd1;
                                byte_done_q <= last_bit;
                            end else if (scl_fall) begin
                                if (byte_done_q) begin
                                    byte_done_q <= 1'b0;
                                    sda_oe      <= 1'b0;
                                    state_q     <= StMack;
                                end else begin
                                    shreg_q <= {shreg_q[6:0], 1'b0};
                                    sda_oe  <= ~shreg_q[6];
                                end
                            end
                        end
                    end
                    StMack: begin
                        if (scl_rise) begin
                            ptr_q <= ptr_inc(ptr_q);
                            if (sda_lvl == I2C_NACK) begin
                                state_q <= StRwait;
                            end else begin
                                fetch_q <= 1'b1;
                                state_q <= StRdata;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.wr_valid  = wr_valid_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.rd_strobe = rd_strobe_q;
    assign bus.rd_addr   = rd_addr_q;

endmodule

// File: tb/tb_i2c_reg_target.sv
// Directed-sequence bench with randomized payloads for i2c_reg_target.
// Glitch-filter steps run only when I2C_RTARGET_GLITCH_FILTER_EN is defined.
module tb_i2c_reg_target;

    localparam int NR = 16;
    localparam int Q  = 8;  // clocks per quarter SCL period

    logic clock;
    logic reset_n;
    logic scl;
    logic sda_m;
    logic sda_oe, busy, ptr_err;
    wire  sda_line = sda_m & ~sda_oe;

    i2c_reg_target_if #(.PTR_W(8)) bus ();

    i2c_reg_target #(
        .I2C_ADDRESS (7'h49),
        .NUM_REGS    (16),
        .PTR_W       (8),
        .FILTER_LEN  (3)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .scl_in  (scl),
        .sda_in  (sda_line),
        .sda_oe  (sda_oe),
        .busy    (busy),
        .ptr_err (ptr_err),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    logic [7:0] mem [NR];

    // Register bank: answers a read request one cycle later.
    always @(posedge clock) begin
        if (!reset_n) bus.rd_data <= 8'h00;
        else if (bus.rd_strobe === 1'b1) bus.rd_data <= mem[bus.rd_addr[3:0]];
    end

    int          n_cmp = 0;
    int          n_fail = 0;
    int          model_ptr = 0;
    logic [15:0] wlog[$];
    int          rlog[$];
    logic [7:0]  tx_bytes[$];
    logic        oe_seen;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        if (bus.wr_valid === 1'b1) wlog.push_back({bus.wr_addr, bus.wr_data});
        if (bus.rd_strobe === 1'b1) rlog.push_back(int'(bus.rd_addr));
        if (sda_oe === 1'b1) oe_seen = 1'b1;
    endtask

    task automatic tick_q();
        repeat (Q) step();
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; tick_q();
        scl   = 1'b1; tick_q();
        sda_m = 1'b0; tick_q();
        scl   = 1'b0; tick_q();
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; tick_q();
        scl   = 1'b1; tick_q();
        sda_m = 1'b1; tick_q();
        tick_q();
    endtask

    task automatic i2c_bit(input logic b, output logic seen);
        sda_m = b; tick_q();
        scl = 1'b1; tick_q();
        seen = sda_line; tick_q();
        scl = 1'b0; tick_q();
    endtask

    task automatic wr_byte(input logic [7:0] b, output logic ack);
        logic dummy;
        for (int i = 7; i >= 0; i--) i2c_bit(b[i], dummy);
        i2c_bit(1'b1, ack);
    endtask

    task automatic rd_byte(input logic nack, output logic [7:0] b);
        logic v;
        for (int i = 7; i >= 0; i--) begin
            i2c_bit(1'b1, v);
            b[i] = v;
        end
        i2c_bit(nack, v);
    endtask

    // Burst write of tx_bytes starting at ptr; expected addresses follow the wrap rule.
    task automatic wr_txn(input int ptr);
        logic a;
        int   n;
        n = tx_bytes.size();
        wlog.delete();
        i2c_start();
        wr_byte(8'h92, a);
        check("wr_addr_ack", 32'(a), 0);
        check("wr_busy", 32'(busy), 1);
        wr_byte(8'(ptr), a);
        check("wr_ptr_ack", 32'(a), 0);
        for (int i = 0; i < n; i++) begin
            wr_byte(tx_bytes[i], a);
            check("wr_data_ack", 32'(a), 0);
        end
        i2c_stop();
        check("wr_busy_after_stop", 32'(busy), 0);
        check("wr_count", 32'(wlog.size()), 32'(n));
        for (int i = 0; i < n && i < wlog.size(); i++) begin
            check("wr_addr", 32'(wlog[i][15:8]), 32'((ptr + i) % NR));
            check("wr_data", 32'(wlog[i][7:0]), 32'(tx_bytes[i]));
        end
        model_ptr = (ptr + n) % NR;
    endtask

    task automatic rd_txn(input logic set_ptr, input int ptr, input int n);
        logic       a;
        logic [7:0] b;
        rlog.delete();
        i2c_start();
        if (set_ptr) begin
            wr_byte(8'h92, a);
            check("rd_waddr_ack", 32'(a), 0);
            wr_byte(8'(ptr), a);
            check("rd_ptr_ack", 32'(a), 0);
            model_ptr = ptr;
            i2c_start();
        end
        wr_byte(8'h93, a);
        check("rd_addr_ack", 32'(a), 0);
        for (int i = 0; i < n; i++) begin
            rd_byte((i == n - 1) ? 1'b1 : 1'b0, b);
            check("rd_data", 32'(b), 32'(mem[(model_ptr + i) % NR]));
        end
        i2c_stop();
        check("rd_busy_after_stop", 32'(busy), 0);
        check("rd_count", 32'(rlog.size()), 32'(n));
        for (int i = 0; i < n && i < rlog.size(); i++)
            check("rd_strobe_addr", 32'(rlog[i]), 32'((model_ptr + i) % NR));
        model_ptr = (model_ptr + n) % NR;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic a;
        int   p;
        int   n;
        for (int i = 0; i < NR; i++) mem[i] = 8'($urandom);
        mem[7] = 8'hC3;
        mem[8] = 8'h3C;
        scl = 1'b1; sda_m = 1'b1; reset_n = 1'b0; oe_seen = 1'b0;
        repeat (4) step();
        check("rst_sda_oe", 32'(sda_oe), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_ptr_err", 32'(ptr_err), 0);
        check("rst_wr_valid", 32'(bus.wr_valid), 0);
        check("rst_rd_strobe", 32'(bus.rd_strobe), 0);
        reset_n = 1'b1;
        tick_q();

        tx_bytes = '{8'hA5, 8'h5A};
        wr_txn(3);
        tx_bytes = '{8'h11, 8'h22};
        wr_txn(15);
        for (int k = 0; k < 3; k++) begin
            p = int'($urandom_range(15, 0));
            n = int'($urandom_range(4, 1));
            tx_bytes.delete();
            for (int j = 0; j < n; j++) tx_bytes.push_back(8'($urandom));
            wr_txn(p);
        end

        rd_txn(1'b1, 7, 2);
        check("model_ptr_after_read", 32'(model_ptr), 9);
        rd_txn(1'b0, 0, 3);
        rd_txn(1'b1, 14, 4);

        // Foreign address: no ACK and no strobes.
        wlog.delete(); rlog.delete(); oe_seen = 1'b0;
        i2c_start();
        wr_byte(8'hA0, a);
        check("foreign_addr_nack", 32'(a), 1);
        wr_byte(8'($urandom), a);
        check("foreign_data_nack", 32'(a), 1);
        check("foreign_busy", 32'(busy), 0);
        i2c_stop();
        check("foreign_oe_seen", 32'(oe_seen), 0);
        check("foreign_wr_count", 32'(wlog.size()), 0);
        check("foreign_rd_count", 32'(rlog.size()), 0);

        // Out-of-range pointer.
        wlog.delete();
        i2c_start();
        wr_byte(8'h92, a);
        check("bad_ptr_addr_ack", 32'(a), 0);
        wr_byte(8'h20, a);
        check("bad_ptr_nack", 32'(a), 1);
        check("bad_ptr_err", 32'(ptr_err), 1);
        check("bad_ptr_busy", 32'(busy), 0);
        wr_byte(8'($urandom), a);
        check("bad_ptr_data_nack", 32'(a), 1);
        i2c_stop();
        check("bad_ptr_err_sticky", 32'(ptr_err), 1);
        check("bad_ptr_wr_count", 32'(wlog.size()), 0);
        i2c_start();
        check("ptr_err_cleared", 32'(ptr_err), 0);
        i2c_stop();

        // Reset while the target is pulling SDA low during a read.
        mem[model_ptr] = 8'($urandom) & 8'h7F;
        i2c_start();
        wr_byte(8'h93, a);
        check("mid_rd_addr_ack", 32'(a), 0);
        check("mid_rd_oe_low_bit", 32'(sda_oe), 1);
        reset_n = 1'b0;
        step();
        check("mid_rd_reset_release", 32'(sda_oe), 0);
        check("mid_rd_reset_busy", 32'(busy), 0);
        repeat (3) step();
        reset_n = 1'b1;
        i2c_stop();
        model_ptr = 0;
        rd_txn(1'b0, 0, 2);

`ifdef I2C_RTARGET_GLITCH_FILTER_EN
        // A 2-clock SDA dip while SCL is high must not look like Sr/STOP.
        p = int'($urandom_range(15, 0));
        wlog.delete();
        i2c_start();
        wr_byte(8'h92, a);
        check("glitch_addr_ack", 32'(a), 0);
        wr_byte(8'(p), a);
        check("glitch_ptr_ack", 32'(a), 0);
        sda_m = 1'b1; tick_q();
        scl = 1'b1;
        repeat (3) step();
        sda_m = 1'b0;
        repeat (2) step();
        sda_m = 1'b1;
        repeat (3) step();
        tick_q();
        scl = 1'b0; tick_q();
        for (int i = 0; i < 7; i++) i2c_bit(1'b1, a);
        i2c_bit(1'b1, a);
        check("glitch_data_ack", 32'(a), 0);
        i2c_stop();
        check("glitch_wr_count", 32'(wlog.size()), 1);
        if (wlog.size() > 0) check("glitch_wr_entry", 32'(wlog[0]), 32'({8'(p), 8'hFF}));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
